dff_fifo_ctrl: RTL and testbench

- Controller that turns a new_DFF_block-style register bank into a synchronous FIFO.
- Upstream of the bank, it drives the bank's write data, write enable and one-hot row select, using a rotating one-hot write pointer.
- Downstream of the bank, it consumes the flattened bank output and selects the head entry with a one-hot read pointer.
- Exposes valid/ready push and pop interfaces to the pipeline.

---
 rtl/dff_fifo_pkg.sv | 15 +
 rtl/dff_fifo_ctrl_onehot_rotate.sv | 40 ++++
 rtl/dff_fifo_ctrl.sv | 115 +++++++++++
 tb/tb_dff_fifo_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dff_fifo_pkg.sv
// ---------------------------------------------------------------------------
// dff_fifo_pkg
//   Shared constants and helpers for the DFF-bank FIFO controller.
//   - cnt_w(depth) : width of an occupancy counter that must hold 0..depth
//   - PTR_RST      : reset/flush value of the one-hot pointers (row 0)
// ---------------------------------------------------------------------------
package dff_fifo_pkg;

    localparam int PTR_RST = 1;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : dff_fifo_pkg

// File: rtl/dff_fifo_ctrl_onehot_rotate.sv
// ---------------------------------------------------------------------------
// onehot_rotate
//   One-hot ring pointer. Starts at bit 0, rotates left by one position per
//   enabled cycle with the top bit wrapping to bit 0.
//   Ports:
//     i_clk   : clock, rising edge
//     i_reset : asynchronous active-low reset (pointer -> bit 0)
//     i_clr   : synchronous clear (pointer -> bit 0), wins over i_en
//     i_en    : advance the pointer
//     o_q     : current one-hot pointer value
// ---------------------------------------------------------------------------
module onehot_rotate
    import dff_fifo_pkg::*;
#(
    parameter int width = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [width-1:0] o_q
);

    localparam logic [width-1:0] RST_VAL = width'(PTR_RST);

    logic [width-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_q <= RST_VAL;
        end else if (i_clr) begin
            r_q <= RST_VAL;
        end else if (i_en) begin
            r_q <= {r_q[width-2:0], r_q[width-1]};
        end
    end

    assign o_q = r_q;

endmodule : onehot_rotate

// File: rtl/dff_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// dff_fifo_ctrl
//   Turns an external register bank (one row per entry, one-hot row select,
//   flattened read-back of all rows) into a synchronous valid/ready FIFO.
//   Ports:
//     i_clk, i_reset      : clock; asynchronous active-low reset
//     i_flush             : synchronous clear of pointers and occupancy
//     i_push_valid/o_push_ready/i_push_data : enqueue handshake
//     o_pop_valid/i_pop_ready/o_pop_data    : dequeue handshake (head entry)
//     o_count, o_almost_full                : occupancy status
//     o_bank_Rin, o_bank_we, o_bank_S       : write side of the bank
//     i_bank_Rout                           : all bank rows, row i at
//                                             [(i+1)*mem_width-1 : i*mem_width]
// ---------------------------------------------------------------------------
module dff_fifo_ctrl
    import dff_fifo_pkg::*;
#(
    parameter int mem_width       = 16,
    parameter int mem_depth       = 16,
    parameter int almost_full_lvl = mem_depth - 2
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_flush,
    input  logic                               i_push_valid,
    output logic                               o_push_ready,
    input  logic [mem_width-1:0]               i_push_data,
    output logic                               o_pop_valid,
    input  logic                               i_pop_ready,
    output logic [mem_width-1:0]               o_pop_data,
    output logic [cnt_w(mem_depth)-1:0]        o_count,
    output logic                               o_almost_full,
    output logic [mem_width-1:0]               o_bank_Rin,
    output logic                               o_bank_we,
    output logic [mem_depth-1:0]               o_bank_S,
    input  logic [mem_width*mem_depth-1:0]     i_bank_Rout
);

    localparam int CW = cnt_w(mem_depth);
    localparam logic [CW-1:0] DEPTH_C = CW'(mem_depth);

    logic [CW-1:0]        r_cnt;
    logic [mem_depth-1:0] w_wr_oh;
    logic [mem_depth-1:0] w_rd_oh;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push_fire;
    logic                 w_pop_fire;

    assign w_full  = (r_cnt == DEPTH_C);
    assign w_empty = (r_cnt == '0);

    assign o_push_ready = !w_full;
    assign o_pop_valid  = !w_empty;

    assign w_push_fire = i_push_valid & o_push_ready & !i_flush;
    assign w_pop_fire  = o_pop_valid  & i_pop_ready  & !i_flush;

    // The reset term makes the write strobe drop the moment reset asserts,
    // not just at the next edge when the counter has been cleared.
    assign o_bank_we  = w_push_fire & i_reset;
    assign o_bank_S   = w_wr_oh;
    assign o_bank_Rin = i_push_data;

    onehot_rotate #(.width(mem_depth)) u_wr_ptr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (i_flush),
        .i_en    (w_push_fire),
        .o_q     (w_wr_oh)
    );

    onehot_rotate #(.width(mem_depth)) u_rd_ptr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (i_flush),
        .i_en    (w_pop_fire),
        .o_q     (w_rd_oh)
    );

    // Occupancy: push-only increments, pop-only decrements, otherwise held.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (i_flush) begin
            r_cnt <= '0;
        end else begin
            case ({w_push_fire, w_pop_fire})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_count       = r_cnt;
    assign o_almost_full = (int'(r_cnt) >= almost_full_lvl);

    // Head-entry select: mask every row with its read-pointer bit, then OR.
    // Because the pointer is one-hot exactly one row survives the mask.
    logic [mem_width-1:0] w_masked [mem_depth];

    for (genvar gi = 0; gi < mem_depth; gi++) begin : g_rd_mask
        assign w_masked[gi] = i_bank_Rout[gi*mem_width +: mem_width]
                              & {mem_width{w_rd_oh[gi]}};
    end

    always_comb begin
        o_pop_data = '0;
        for (int i = 0; i < mem_depth; i++) begin
            o_pop_data = o_pop_data | w_masked[i];
        end
    end

endmodule : dff_fifo_ctrl

// File: tb/tb_dff_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dff_fifo_ctrl
//   Directed bench for dff_fifo_ctrl with a 4 x 16 bank model attached.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dff_fifo_ctrl;

    localparam int W = 16;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          push_valid;
    logic          push_ready;
    logic [W-1:0]  push_data;
    logic          pop_valid;
    logic          pop_ready;
    logic [W-1:0]  pop_data;
    logic [2:0]    count;
    logic          almost_full;
    logic [W-1:0]  bank_Rin;
    logic          bank_we;
    logic [D-1:0]  bank_S;
    logic [W*D-1:0] bank_Rout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Bank model: row-select + write-enable capture on the rising edge.
    logic [W-1:0] mem [D];
    always @(posedge clk) begin
        if (bank_we) begin
            for (int i = 0; i < D; i++)
                if (bank_S[i]) mem[i] <= bank_Rin;
        end
    end
    for (genvar gi = 0; gi < D; gi++) begin : g_rout
        assign bank_Rout[gi*W +: W] = mem[gi];
    end

    dff_fifo_ctrl #(.mem_width(W), .mem_depth(D)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_flush       (flush),
        .i_push_valid  (push_valid),
        .o_push_ready  (push_ready),
        .i_push_data   (push_data),
        .o_pop_valid   (pop_valid),
        .i_pop_ready   (pop_ready),
        .o_pop_data    (pop_data),
        .o_count       (count),
        .o_almost_full (almost_full),
        .o_bank_Rin    (bank_Rin),
        .o_bank_we     (bank_we),
        .o_bank_S      (bank_S),
        .i_bank_Rout   (bank_Rout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        push_data = '0;
        for (int i = 0; i < D; i++) mem[i] = '0;

        // Reset then idle
        tick(); tick();
        #3 reset = 1'b1;
        tick();
        chk("rst_push_ready", 32'(push_ready), 32'd1);
        chk("rst_pop_valid",  32'(pop_valid),  32'd0);
        chk("rst_count",      32'(count),      32'd0);
        chk("rst_bank_S",     32'(bank_S),     32'h1);
        chk("rst_bank_we",    32'(bank_we),    32'd0);
        chk("rst_almost_full",32'(almost_full),32'd0);

        // Fill: A001..A004
        for (int k = 0; k < 4; k++) begin
            push_valid = 1'b1; push_data = W'(16'hA001 + k);
            #1;
            chk("fill_bank_S",  32'(bank_S),  32'(1 << k));
            chk("fill_bank_we", 32'(bank_we), 32'd1);
            chk("fill_count",   32'(count),   32'(k));
            chk("fill_pop_valid", 32'(pop_valid), (k == 0) ? 32'd0 : 32'd1);
            tick();
        end
        push_data = 16'hA005;
        #1;
        chk("full_count",       32'(count),       32'd4);
        chk("full_push_ready",  32'(push_ready),  32'd0);
        chk("full_bank_we",     32'(bank_we),     32'd0);
        chk("full_almost_full", 32'(almost_full), 32'd1);
        tick();
        chk("full_hold_count",  32'(count),       32'd4);
        push_valid = 1'b0;

        // Drain in order
        pop_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_pop_valid", 32'(pop_valid), 32'd1);
            chk("drain_pop_data",  32'(pop_data),  32'(16'hA001 + k));
            if (k == 0) chk("drain_push_ready_still0", 32'(push_ready), 32'd0);
            tick();
            if (k == 0) chk("drain_push_ready_rise", 32'(push_ready), 32'd1);
        end
        chk("drained_pop_valid", 32'(pop_valid), 32'd0);
        chk("drained_count",     32'(count),     32'd0);
        chk("drained_bank_S",    32'(bank_S),    32'h1);
        // Empty: pop_ready ignored, simultaneous push proceeds; read pointer
        // wrapped to row 0 so the new entry is the head.
        push_valid = 1'b1; push_data = 16'hB000;
        #1;
        chk("empty_push_we",     32'(bank_we),   32'd1);
        chk("empty_no_fallthru", 32'(pop_valid), 32'd0);
        tick();
        push_valid = 1'b0;
        #1;
        chk("wrap_rd_pop_data",  32'(pop_data),  32'hB000);
        chk("wrap_count",        32'(count),     32'd1);
        tick();
        pop_ready = 1'b0;
        chk("wrap_empty",        32'(pop_valid), 32'd0);

        // Sustained push/pop at count=2 across the wrap
        push_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push_data = W'(16'hC000 + k);
            tick();
        end
        pop_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            push_data = W'(16'hC002 + k);
            #1;
            chk("ss_count",       32'(count),       32'd2);
            chk("ss_pop_data",    32'(pop_data),    32'(16'hC000 + k));
            chk("ss_almost_full", 32'(almost_full), 32'd1);
            chk("ss_bank_we",     32'(bank_we),     32'd1);
            tick();
        end
        push_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("ss_tail_pop_data", 32'(pop_data), 32'(16'hC00A + k));
            tick();
        end
        pop_ready = 1'b0;
        chk("ss_end_count", 32'(count), 32'd0);

        // Flush with push and pop both requested
        push_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_data = W'(16'hD000 + k);
            tick();
        end
        chk("pre_flush_count", 32'(count), 32'd3);
        flush = 1'b1; pop_ready = 1'b1; push_data = 16'hD0FF;
        #1;
        chk("flush_bank_we", 32'(bank_we), 32'd0);
        tick();
        flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        #1;
        chk("flush_count",     32'(count),     32'd0);
        chk("flush_pop_valid", 32'(pop_valid), 32'd0);
        chk("flush_bank_S",    32'(bank_S),    32'h1);

        // Asynchronous reset mid-operation
        push_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push_data = W'(16'hE000 + k);
            tick();
        end
        push_data = 16'hE0FF;
        #1;
        chk("pre_arst_count", 32'(count),   32'd2);
        chk("pre_arst_we",    32'(bank_we), 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_count",     32'(count),     32'd0);
        chk("arst_pop_valid", 32'(pop_valid), 32'd0);
        chk("arst_bank_we",   32'(bank_we),   32'd0);
        chk("arst_bank_S",    32'(bank_S),    32'h1);
        push_valid = 1'b0;
        tick();
        #3 reset = 1'b1;
        tick();
        push_valid = 1'b1; push_data = 16'hF000;
        #1;
        chk("post_arst_bank_S",  32'(bank_S),  32'h1);
        chk("post_arst_bank_we", 32'(bank_we), 32'd1);
        tick();
        push_valid = 1'b0;
        #1;
        chk("post_arst_pop_valid", 32'(pop_valid), 32'd1);
        chk("post_arst_pop_data",  32'(pop_data),  32'hF000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dff_fifo_ctrl
